// File: rtl/key_event_decoder.sv
// Keymap-driven HID keycode decoder: per-key held levels, press/release/auto-repeat
// strobes and press-toggled latches, all registered one cycle behind the keycode word.
module key_event_decoder #(
    parameter int                      NUM_SLOTS    = 4,
    parameter int                      NUM_KEYS     = 8,
    parameter logic [NUM_KEYS*8-1:0]   KEYMAP       = {8'd41, 8'd40, 8'd7, 8'd21,
                                                       8'd22, 8'd4, 8'd26, 8'd44},
    parameter int                      REPEAT_DELAY = 25_000_000,
    parameter int                      REPEAT_RATE  = 5_000_000
) (
    input  logic                     i_Clock_50,
    input  logic                     i_Reset_h,
    input  logic [8*NUM_SLOTS-1:0]   i_keycode,
    input  logic [NUM_KEYS-1:0]      i_toggle_clr,
    output logic [NUM_KEYS-1:0]      o_held,
    output logic [NUM_KEYS-1:0]      o_press,
    output logic [NUM_KEYS-1:0]      o_release,
    output logic [NUM_KEYS-1:0]      o_repeat,
    output logic [NUM_KEYS-1:0]      o_toggle,
    output logic                     o_any_held
);

    localparam int MAX_COUNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW        = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic [NUM_KEYS-1:0] r_toggle;
    logic                r_any_held;

    // A zero keymap entry must never match, otherwise empty slots would light it up.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if ((KEYMAP[8*k +: 8] != 8'd0) && (i_keycode[8*i +: 8] == KEYMAP[8*k +: 8])) begin
                    w_match[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_Clock_50 or posedge i_Reset_h) begin
        if (i_Reset_h) begin
            r_held     <= '0;
            r_press    <= '0;
            r_release  <= '0;
            r_toggle   <= '0;
            r_any_held <= 1'b0;
        end else begin
            r_held     <= w_match;
            r_press    <= w_match & ~r_held;
            r_release  <= ~w_match & r_held;
            r_toggle   <= (r_toggle ^ (w_match & ~r_held)) & ~i_toggle_clr;
            r_any_held <= |w_match;
        end
    end

    generate
        if (REPEAT_DELAY != 0) begin : g_repeat
            localparam logic [CW-1:0] DELAY_C = CW'(REPEAT_DELAY);
            localparam logic [CW-1:0] RATE_C  = CW'(REPEAT_RATE);

            logic [CW-1:0]       r_cnt [NUM_KEYS];
            logic [NUM_KEYS-1:0] r_first;
            logic [NUM_KEYS-1:0] r_repeat;

            // r_first selects the initial delay; after the first repeat the rate applies.
            always_ff @(posedge i_Clock_50 or posedge i_Reset_h) begin
                if (i_Reset_h) begin
                    for (int k = 0; k < NUM_KEYS; k++) begin
                        r_cnt[k] <= '0;
                    end
                    r_first  <= '1;
                    r_repeat <= '0;
                end else begin
                    for (int k = 0; k < NUM_KEYS; k++) begin
                        if (w_match[k] && !r_held[k]) begin
                            r_cnt[k]    <= CW'(1);
                            r_first[k]  <= 1'b1;
                            r_repeat[k] <= 1'b0;
                        end else if (w_match[k]) begin
                            if (r_first[k] && (r_cnt[k] == DELAY_C)) begin
                                r_repeat[k] <= 1'b1;
                                r_cnt[k]    <= CW'(1);
                                r_first[k]  <= 1'b0;
                            end else if (!r_first[k] && (r_cnt[k] == RATE_C)) begin
                                r_repeat[k] <= 1'b1;
                                r_cnt[k]    <= CW'(1);
                            end else begin
                                r_repeat[k] <= 1'b0;
                                r_cnt[k]    <= r_cnt[k] + CW'(1);
                            end
                        end else begin
                            r_cnt[k]    <= '0;
                            r_first[k]  <= 1'b1;
                            r_repeat[k] <= 1'b0;
                        end
                    end
                end
            end

            assign o_repeat = r_repeat;
        end else begin : g_no_repeat
            assign o_repeat = '0;
        end
    endgenerate

    assign o_held     = r_held;
    assign o_press    = r_press;
    assign o_release  = r_release;
    assign o_toggle   = r_toggle;
    assign o_any_held = r_any_held;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: one instance with a short repeat timing,
// one with auto-repeat disabled, both driven from a single linear sequence.
module tb_key_event_decoder;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] keycode;
   logic [7:0]  toggleClr;
   logic [7:0]  held, press, releaseS, repeatS, toggle;
   logic        anyHeld;

   logic [31:0] keycode2;
   logic [7:0]  held2, press2, release2, repeat2, toggle2;
   logic        anyHeld2;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   key_event_decoder #(.REPEAT_DELAY(10), .REPEAT_RATE(4)) dut (
      .i_Clock_50  (clock),
      .i_Reset_h   (reset),
      .i_keycode   (keycode),
      .i_toggle_clr(toggleClr),
      .o_held      (held),
      .o_press     (press),
      .o_release   (releaseS),
      .o_repeat    (repeatS),
      .o_toggle    (toggle),
      .o_any_held  (anyHeld)
   );

   key_event_decoder #(.REPEAT_DELAY(0), .REPEAT_RATE(1)) dutNoRep (
      .i_Clock_50  (clock),
      .i_Reset_h   (reset),
      .i_keycode   (keycode2),
      .i_toggle_clr(8'h00),
      .o_held      (held2),
      .o_press     (press2),
      .o_release   (release2),
      .o_repeat    (repeat2),
      .o_toggle    (toggle2),
      .o_any_held  (anyHeld2)
   );

   // Drive inputs just after a rising edge, then wait for the next edge to register them.
   task automatic applyStimulus(input logic [31:0] kc, input logic [7:0] clr);
      keycode   = kc;
      toggleClr = clr;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      int pressCount;
      int releaseCount;
      int repeatCount;

      reset     = 1'b1;
      keycode   = '0;
      keycode2  = '0;
      toggleClr = '0;
      repeat (2) @(posedge clock);
      #1;
      checkOutput("rst_held", held, 8'h00);
      checkOutput("rst_toggle", toggle, 8'h00);
      checkOutput("rst_any", anyHeld, 1'b0);
      reset = 1'b0;

      $display("[TB] reset behaviour");
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("idle_held", held, 8'h00);
      applyStimulus(32'h0000_1A04, 8'h00);
      checkOutput("pre_held", held, 8'h06);
      checkOutput("pre_press", press, 8'h06);
      checkOutput("pre_toggle", toggle, 8'h06);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("async_held", held, 8'h00);
      checkOutput("async_press", press, 8'h00);
      checkOutput("async_toggle", toggle, 8'h00);
      checkOutput("async_any", anyHeld, 1'b0);
      @(posedge clock);
      #1;
      checkOutput("inrst_held", held, 8'h00);
      reset = 1'b0;
      applyStimulus(32'h0000_1A04, 8'h00);
      checkOutput("post_held", held, 8'h06);
      checkOutput("post_press", press, 8'h06);
      checkOutput("post_any", anyHeld, 1'b1);
      applyStimulus(32'h0000_1A04, 8'h00);
      checkOutput("post_press_drop", press, 8'h00);
      checkOutput("post_held2", held, 8'h06);

      $display("[TB] slot independence");
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("rel_release", releaseS, 8'h06);
      checkOutput("rel_held", held, 8'h00);
      checkOutput("rel_any", anyHeld, 1'b0);
      applyStimulus(32'h2C00_0000, 8'h00);
      checkOutput("slot3_held", held, 8'h01);
      checkOutput("slot3_press", press, 8'h01);
      applyStimulus(32'h0000_002C, 8'h00);
      checkOutput("slot0_held", held, 8'h01);
      checkOutput("slot0_press", press, 8'h00);
      checkOutput("slot0_release", releaseS, 8'h00);
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("space_release", releaseS, 8'h01);
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("empty_held", held, 8'h00);
      checkOutput("empty_release", releaseS, 8'h00);

      $display("[TB] auto-repeat");
      applyStimulus(32'h0000_001A, 8'h00);
      checkOutput("rep_press_e0", press, 8'h02);
      checkOutput("rep_none_e0", repeatS, 8'h00);
      for (int j = 1; j <= 24; j++) begin
         applyStimulus(32'h0000_001A, 8'h00);
         checkOutput($sformatf("rep_e0_plus_%0d", j), repeatS,
                     (j == 10 || j == 14 || j == 18 || j == 22) ? 8'h02 : 8'h00);
         checkOutput($sformatf("rep_press_%0d", j), press, 8'h00);
      end
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("rep_release", releaseS, 8'h02);
      checkOutput("rep_at_release", repeatS, 8'h00);
      for (int j = 0; j < 6; j++) begin
         applyStimulus(32'h0000_0000, 8'h00);
         checkOutput($sformatf("rep_after_%0d", j), repeatS, 8'h00);
      end

      $display("[TB] drop restarts delay");
      applyStimulus(32'h0000_0016, 8'h00);
      checkOutput("drop_press1", press, 8'h08);
      for (int j = 0; j < 5; j++) applyStimulus(32'h0000_0016, 8'h00);
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("drop_release", releaseS, 8'h08);
      applyStimulus(32'h0000_0016, 8'h00);
      checkOutput("drop_press2", press, 8'h08);
      for (int j = 1; j <= 10; j++) begin
         applyStimulus(32'h0000_0016, 8'h00);
         checkOutput($sformatf("drop_rep_%0d", j), repeatS, (j == 10) ? 8'h08 : 8'h00);
      end
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("drop_release2", releaseS, 8'h08);

      $display("[TB] simultaneous events");
      applyStimulus(32'h0000_0407, 8'h00);
      checkOutput("sim_press_a", press, 8'h24);
      checkOutput("sim_held_a", held, 8'h24);
      applyStimulus(32'h0000_1A16, 8'h00);
      checkOutput("sim_release", releaseS, 8'h24);
      checkOutput("sim_press_b", press, 8'h0A);
      checkOutput("sim_held_b", held, 8'h0A);
      checkOutput("sim_any", anyHeld, 1'b1);
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("sim_release_b", releaseS, 8'h0A);
      checkOutput("sim_any_off", anyHeld, 1'b0);

      $display("[TB] toggle");
      for (int n = 1; n <= 3; n++) begin
         applyStimulus(32'h0000_0028, 8'h00);
         checkOutput($sformatf("tog_press_%0d", n), toggle[6], n[0]);
         applyStimulus(32'h0000_0000, 8'h00);
         checkOutput($sformatf("tog_hold_%0d", n), toggle[6], n[0]);
      end
      applyStimulus(32'h0000_0028, 8'h40);
      checkOutput("tog_clr_press", press[6], 1'b1);
      checkOutput("tog_clr_wins", toggle[6], 1'b0);
      applyStimulus(32'h0000_0000, 8'h00);
      checkOutput("tog_clr_stays", toggle[6], 1'b0);

      $display("[TB] repeat disabled");
      pressCount   = 0;
      releaseCount = 0;
      repeatCount  = 0;
      keycode2 = 32'h0000_002C;
      for (int j = 0; j < 1000; j++) begin
         @(posedge clock);
         #1;
         pressCount   += int'(press2[0]);
         releaseCount += int'(release2[0]);
         repeatCount  += int'(repeat2 != 8'h00);
      end
      checkOutput("norep_held", held2, 8'h01);
      keycode2 = 32'h0000_0000;
      for (int j = 0; j < 5; j++) begin
         @(posedge clock);
         #1;
         pressCount   += int'(press2[0]);
         releaseCount += int'(release2[0]);
         repeatCount  += int'(repeat2 != 8'h00);
      end
      checkOutput("norep_presses", pressCount, 1);
      checkOutput("norep_releases", releaseCount, 1);
      checkOutput("norep_repeats", repeatCount, 0);
      checkOutput("norep_toggle", toggle2, 8'h01);
      checkOutput("norep_any", anyHeld2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
